// File: rtl/reg_permuter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_permuter_pkg
// Brief    : Opcode and FSM state types shared by the register permuter.
// Revision : 1.0 - initial release
// ============================================================================
package reg_permuter_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP     = 3'd0,
        OP_LOAD    = 3'd1,
        OP_SWAP    = 3'd2,
        OP_ROT_L   = 3'd3,
        OP_ROT_R   = 3'd4,
        OP_REVERSE = 3'd5
    } perm_op_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REV  = 1'b1
    } perm_state_t;

endpackage : reg_permuter_pkg
`default_nettype wire

// File: rtl/reg_permuter.sv
`default_nettype none
// ============================================================================
// Module   : reg_permuter
// Brief    : DEPTH x WIDTH register bank with load, swap, rotate and reverse.
// Revision : 1.0 - initial release
// ============================================================================
module reg_permuter
    import reg_permuter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [OP_W-1:0]          op,
    input  logic [IDX_W-1:0]         idx_a,
    input  logic [IDX_W-1:0]         idx_b,
    input  logic [WIDTH*DEPTH-1:0]   load_data,
    output logic [WIDTH*DEPTH-1:0]   regs_out,
    output logic                     done,
    output logic                     err
);

    localparam logic [IDX_W:0]   c_DEPTH_EXT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] c_HI_INIT   = IDX_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] w_next [DEPTH];

    perm_state_t      r_state;
    perm_state_t      w_state_next;
    logic [IDX_W-1:0] r_lo;
    logic [IDX_W-1:0] r_hi;
    logic [IDX_W-1:0] w_lo_next;
    logic [IDX_W-1:0] w_hi_next;
    logic [IDX_W-1:0] w_lo_inc;
    logic [IDX_W-1:0] w_hi_dec;
    logic             r_done;
    logic             r_err;
    logic             w_done_next;
    logic             w_err_next;
    logic             w_accept;
    logic             w_idx_bad;

    assign op_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept  = op_valid && op_ready;
    assign w_lo_inc  = r_lo + IDX_W'(1);
    assign w_hi_dec  = r_hi - IDX_W'(1);
    // Indices can only exceed the bank when DEPTH is not a power of two.
    assign w_idx_bad = ({1'b0, idx_a} >= c_DEPTH_EXT) || ({1'b0, idx_b} >= c_DEPTH_EXT);

    always_comb begin
        w_next       = r_regs;
        w_state_next = r_state;
        w_lo_next    = r_lo;
        w_hi_next    = r_hi;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (op)
                        OP_NOP: begin
                            w_done_next = 1'b1;
                        end
                        OP_LOAD: begin
                            for (int i = 0; i < DEPTH; i++) begin
                                w_next[i] = load_data[i*WIDTH +: WIDTH];
                            end
                            w_done_next = 1'b1;
                        end
                        OP_SWAP: begin
                            if (w_idx_bad) begin
                                w_err_next = 1'b1;
                            end else begin
                                w_next[idx_a] = r_regs[idx_b];
                                w_next[idx_b] = r_regs[idx_a];
                                w_done_next   = 1'b1;
                            end
                        end
                        OP_ROT_L: begin
                            for (int i = 0; i < DEPTH; i++) begin
                                w_next[i] = r_regs[(i + 1) % DEPTH];
                            end
                            w_done_next = 1'b1;
                        end
                        OP_ROT_R: begin
                            for (int i = 0; i < DEPTH; i++) begin
                                w_next[i] = r_regs[(i + DEPTH - 1) % DEPTH];
                            end
                            w_done_next = 1'b1;
                        end
                        OP_REVERSE: begin
                            // Accept edge only arms the pointers; swapping starts next edge.
                            w_state_next = ST_REV;
                            w_lo_next    = '0;
                            w_hi_next    = c_HI_INIT;
                        end
                        default: begin
                            w_err_next = 1'b1;
                        end
                    endcase
                end
            end
            ST_REV: begin
                w_next[r_lo] = r_regs[r_hi];
                w_next[r_hi] = r_regs[r_lo];
                w_lo_next    = w_lo_inc;
                w_hi_next    = w_hi_dec;
                if (w_lo_inc >= w_hi_dec) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_state <= ST_IDLE;
            r_lo    <= '0;
            r_hi    <= c_HI_INIT;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_regs  <= w_next;
            r_state <= w_state_next;
            r_lo    <= w_lo_next;
            r_hi    <= w_hi_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    assign done = r_done;
    assign err  = r_err;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_pack
            assign regs_out[g*WIDTH +: WIDTH] = r_regs[g];
        end
    endgenerate

endmodule : reg_permuter
`default_nettype wire

// File: tb/tb_reg_permuter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_permuter
// Brief    : Directed self-checking bench for reg_permuter (DEPTH 4 and 5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_permuter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH=4 instance signals
    logic        v4, rdy4, done4, err4;
    logic [2:0]  op4;
    logic [1:0]  a4, b4;
    logic [31:0] ld4, q4;

    // DEPTH=5 instance signals
    logic        v5, rdy5, done5, err5;
    logic [2:0]  op5;
    logic [2:0]  a5, b5;
    logic [39:0] ld5, q5;

    int checks   = 0;
    int failures = 0;

    reg_permuter #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .op_valid(v4), .op_ready(rdy4), .op(op4),
        .idx_a(a4), .idx_b(b4), .load_data(ld4), .regs_out(q4),
        .done(done4), .err(err4)
    );

    reg_permuter #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .op_valid(v5), .op_ready(rdy5), .op(op5),
        .idx_a(a5), .idx_b(b5), .load_data(ld5), .regs_out(q5),
        .done(done5), .err(err5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        v4 = 1'b1; op4 = 3'd1; a4 = '0; b4 = '0; ld4 = 32'hDEADBEEF;
        v5 = 1'b0; op5 = 3'd0; a5 = '0; b5 = '0; ld5 = '0;

        // Reset wins over a simultaneous LOAD
        tick();
        chk("rdy_in_rst", 64'(rdy4), 64'd0);
        tick();
        chk("rst_regs", 64'(q4), 64'd0);
        chk("rst_done", 64'(done4), 64'd0);
        chk("rst_err", 64'(err4), 64'd0);
        v4 = 1'b0;
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 64'(rdy4), 64'd1);

        // LOAD
        v4 = 1'b1; op4 = 3'd1; ld4 = 32'h44332211;
        tick();
        v4 = 1'b0;
        chk("load_regs", 64'(q4), 64'h44332211);
        chk("load_done", 64'(done4), 64'd1);
        tick();
        chk("load_done_clr", 64'(done4), 64'd0);

        // SWAP 0,3 then SWAP 2,2
        v4 = 1'b1; op4 = 3'd2; a4 = 2'd0; b4 = 2'd3;
        tick();
        chk("swap03_regs", 64'(q4), 64'h11332244);
        chk("swap03_done", 64'(done4), 64'd1);
        a4 = 2'd2; b4 = 2'd2;
        tick();
        chk("swap22_regs", 64'(q4), 64'h11332244);
        chk("swap22_done", 64'(done4), 64'd1);
        chk("swap22_err", 64'(err4), 64'd0);
        a4 = 2'd0; b4 = 2'd3;
        tick();
        chk("swap_back", 64'(q4), 64'h44332211);

        // ROT_L then ROT_R back-to-back
        op4 = 3'd3;
        tick();
        chk("rotl_regs", 64'(q4), 64'h11443322);
        chk("rotl_done", 64'(done4), 64'd1);
        chk("rotl_ready", 64'(rdy4), 64'd1);
        op4 = 3'd4;
        tick();
        chk("rotr_regs", 64'(q4), 64'h44332211);
        chk("rotr_done", 64'(done4), 64'd1);

        // Reserved opcode then NOP
        op4 = 3'd6;
        tick();
        chk("rsv_err", 64'(err4), 64'd1);
        chk("rsv_done", 64'(done4), 64'd0);
        chk("rsv_regs", 64'(q4), 64'h44332211);
        op4 = 3'd0;
        tick();
        chk("nop_done", 64'(done4), 64'd1);
        chk("nop_err", 64'(err4), 64'd0);

        // REVERSE, even depth, with a stray LOAD offered during REV
        op4 = 3'd5;
        tick();
        op4 = 3'd1; ld4 = 32'hDEADBEEF;
        chk("rev_e0_ready", 64'(rdy4), 64'd0);
        chk("rev_e0_regs", 64'(q4), 64'h44332211);
        chk("rev_e0_done", 64'(done4), 64'd0);
        tick();
        v4 = 1'b0;
        chk("rev_e1_regs", 64'(q4), 64'h11332244);
        chk("rev_e1_ready", 64'(rdy4), 64'd0);
        chk("rev_e1_done", 64'(done4), 64'd0);
        tick();
        chk("rev_e2_regs", 64'(q4), 64'h11223344);
        chk("rev_e2_done", 64'(done4), 64'd1);
        chk("rev_e2_ready", 64'(rdy4), 64'd1);
        tick();
        chk("rev_done_clr", 64'(done4), 64'd0);
        chk("rev_ignored_load", 64'(q4), 64'h11223344);

        // REVERSE, odd depth
        v5 = 1'b1; op5 = 3'd1; ld5 = 40'h0504030201;
        tick();
        chk("d5_load", 64'(q5), 64'h0504030201);
        op5 = 3'd5;
        tick();
        v5 = 1'b0;
        chk("d5_e0_ready", 64'(rdy5), 64'd0);
        tick();
        chk("d5_e1_regs", 64'(q5), 64'h0104030205);
        chk("d5_e1_done", 64'(done5), 64'd0);
        tick();
        chk("d5_e2_regs", 64'(q5), 64'h0102030405);
        chk("d5_e2_done", 64'(done5), 64'd1);
        chk("d5_e2_ready", 64'(rdy5), 64'd1);

        // Out-of-range SWAP index
        v5 = 1'b1; op5 = 3'd2; a5 = 3'd6; b5 = 3'd1;
        tick();
        v5 = 1'b0;
        chk("d5_badidx_err", 64'(err5), 64'd1);
        chk("d5_badidx_done", 64'(done5), 64'd0);
        chk("d5_badidx_regs", 64'(q5), 64'h0102030405);

        // Reset one cycle after REVERSE acceptance
        v4 = 1'b1; op4 = 3'd5;
        tick();
        v4 = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_regs", 64'(q4), 64'd0);
        chk("mid_rst_done", 64'(done4), 64'd0);
        chk("mid_rst_ready", 64'(rdy4), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_after", 64'(rdy4), 64'd1);
        tick();
        chk("mid_rst_no_done", 64'(done4), 64'd0);
        chk("mid_rst_regs_after", 64'(q4), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_permuter
`default_nettype wire

// File: doc/reg_permuter.md
# reg_permuter

Parametrised bank of DEPTH registers, each WIDTH bits wide, supporting parallel load, indexed pairwise swap, rotate left/right, and a multi-cycle full reverse. Commands arrive one at a time over a valid/ready handshake. It generalises the team's two-register load/swap cell to N entries and adds permutation modes. It sits as a datapath staging buffer between a producer (parallel load) and downstream consumers that read the flat `regs_out` bus.

## Interface
- `WIDTH`, 8, bits per entry (≥1)
- `DEPTH`, 4, number of entries (≥2)
- `IDX_W`, $clog2(DEPTH), derived localparam, index width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `op_valid`  in  1  command present
- `op_ready`  out  1  block can accept a command; equals (state==IDLE && !rst)
- `op`  in  3  opcode: NOP=0, LOAD=1, SWAP=2, ROT_L=3, ROT_R=4, REVERSE=5; 6 and 7 are reserved
- `idx_a`, `idx_b`  in  IDX_W  entry indices used by SWAP
- `load_data`  in  WIDTH*DEPTH  LOAD source; entry i is `[i*WIDTH +: WIDTH]`
- `regs_out`  out  WIDTH*DEPTH  current register contents, same packing, driven directly from the registers
- `done`  out  1  one-cycle pulse: command completed
- `err`  out  1  one-cycle pulse: command rejected, registers unchanged

## Operation
- **Accept:** a command is accepted at a rising edge where `op_valid && op_ready`.
  - When `op_ready` is low, `op_valid` is ignored; the requester holds the command.
- **LOAD:** all entries take `load_data` at the accept edge.
- **SWAP:** entries `idx_a` and `idx_b` exchange contents at the accept edge.
  - `idx_a == idx_b`: no data change; `done` still pulses.
  - Either index ≥ DEPTH (possible when DEPTH is not a power of 2): no change; `err` pulses instead of `done`.
- **ROT_L:** new[i] = old[(i+1) mod DEPTH].
- **ROT_R:** new[i] = old[(i-1+DEPTH) mod DEPTH].
- **NOP and reserved opcodes:** no data change; NOP pulses `done`, reserved opcodes pulse `err`.
- **REVERSE:** FSM with states IDLE and REV; pointers `lo`/`hi` are IDX_W-bit registers.
  - Accept edge: IDLE→REV, lo=0, hi=DEPTH-1; no data change at this edge.
  - Each REV edge: swap entries[lo] and [hi], then lo+1, hi-1.
  - Exit: on the edge where the post-increment lo ≥ hi, go REV→IDLE and pulse `done`.
  - Total floor(DEPTH/2) swap edges; for odd DEPTH the middle entry is untouched.
- **Outputs:** `done` and `err` are registered and never high together.

## Timing
- **Reset values:** all entries 0, state IDLE, lo=0, hi=DEPTH-1, `done`=0, `err`=0; `op_ready`=0 while `rst` is high.
- **Single-cycle ops (LOAD/SWAP/ROT/NOP):**
  - Data updates at the accept edge E0.
  - `done`/`err` are high in the cycle after E0.
  - `op_ready` stays high, so back-to-back commands are accepted every cycle.
- **REVERSE:**
  - Accept at E0; swaps at E1..E(DEPTH/2).
  - `done` is high and `op_ready` returns high in the same cycle, following edge E(DEPTH/2).
  - `op_ready` is low from after E0 through E(DEPTH/2).
- **Reset mid-REVERSE:** aborts the operation and clears all entries; no `done` is produced.
- **Reset and `op_valid` at the same edge:** reset wins; the command is not accepted.

## Structure
- Package `reg_permuter_pkg` holds:
  - opcode enum typedef `perm_op_t` and opcode constants
  - FSM state typedef `perm_state_t` (IDLE, REV)
- Single module, no sub-module. Storage is an unpacked array of DEPTH×WIDTH, packed onto `regs_out` via a generate loop.

## Test plan
All cases use WIDTH=8, DEPTH=4 unless stated.
- **Reset then load:** reset, then LOAD 32'h44332211 → `regs_out`=32'h44332211, `done`=1 for exactly one cycle.
- **Swap:** SWAP idx_a=0, idx_b=3 on 32'h44332211 → 32'h11332244. Then SWAP idx_a=2, idx_b=2 → unchanged, `done` pulses.
- **Rotate:** ROT_L on 32'h44332211 → 32'h11443322. Then ROT_R → 32'h44332211. Issue both back-to-back with `op_valid` held high → two `done` pulses on consecutive cycles.
- **Reverse, even DEPTH:** REVERSE on 32'h44332211 → `op_ready` low for 2 cycles, result 32'h11223344. Confirm that `done` and `op_ready` rise together, and that an `op_valid` pulse during REV is ignored.
- **Reverse, odd DEPTH:**
  - DEPTH=5, data entries 0..4 = 1..5 → result 5,4,3,2,1 after 2 swap cycles.
  - SWAP idx_a=6 → `err` pulse, data unchanged.
- **Reset mid-REVERSE:** assert `rst` one cycle after acceptance → all entries 0, no `done`, `op_ready`=1 the cycle after `rst` drops.
